// File: rtl/myuart_pkg.sv
// myuart_pkg: shared UART encodings, limits and the tx FSM state type
package myuart_pkg;
    localparam logic [1:0] PARITY_NONE = 2'b00;
    localparam logic [1:0] PARITY_EVEN = 2'b01;
    localparam logic [1:0] PARITY_ODD  = 2'b10;
    localparam logic [1:0] STOP_NUM_1  = 2'b00;
    localparam logic [1:0] STOP_NUM_15 = 2'b01;
    localparam logic [1:0] STOP_NUM_2  = 2'b10;
    localparam int DATA_NUM_MIN = 5;
    localparam int DATA_NUM_MAX = 8;
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} tx_state_t;
endpackage

// File: rtl/myuart_baud_cnt.sv
// myuart_baud_cnt: loadable down-counter with terminal-count tick
// ports: clk_i/rst_i clock and sync reset; load_i/load_val_i load a count;
//        en_i allows counting down; cnt_o current count; tick_o high at count 0 while enabled
module myuart_baud_cnt #(
    parameter int W = 17
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         tick_o
);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb begin
        cnt_d = load_i ? load_val_i : (en_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
    assign cnt_o  = cnt_q;
    assign tick_o = en_i && cnt_q == '0;
endmodule

// File: rtl/myuart_tx.sv
// myuart_tx: UART serial transmit engine (start, LSB-first data, optional parity, stop)
// ports: clk_i/rst_i clock and sync reset; shoot_i starts a frame with datatx_i and the
//        frame config (data_bit_num_i, parity_type_i, stop_bit_num_i, divisor_i);
//        tx_o serial line, busy_o frame in progress, done_o pulse in last stop cycle
module myuart_tx
    import myuart_pkg::*;
#(
    parameter int DIV_W    = 16,
    parameter int DATA_MAX = DATA_NUM_MAX
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             shoot_i,
    input  logic [7:0]       datatx_i,
    input  logic [3:0]       data_bit_num_i,
    input  logic [1:0]       parity_type_i,
    input  logic [1:0]       stop_bit_num_i,
    input  logic [DIV_W-1:0] divisor_i,
    output logic             tx_o,
    output logic             busy_o,
    output logic             done_o
);
    localparam int CW = DIV_W + 1;
    tx_state_t        state_q, state_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_q, par_d;
    logic [2:0]       bit_q, bit_d;
    logic [3:0]       dn_q, dn_d;
    logic [1:0]       pt_q, pt_d, sb_q, sb_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             tx_q, tx_d, busy_q, busy_d, done_q, done_d;
    logic             load, tick, par_en;
    logic [CW-1:0]    load_val, cnt, div_m1, stop_len;
    logic [3:0]       dn_c;
    logic [DIV_W-1:0] div_c;

    myuart_baud_cnt #(.W(CW)) u_baud (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (load),
        .load_val_i (load_val),
        .en_i       (state_q != ST_IDLE),
        .cnt_o      (cnt),
        .tick_o     (tick)
    );

    always_comb begin
        dn_c = data_bit_num_i < 4'(DATA_NUM_MIN) ? 4'(DATA_NUM_MIN) :
               data_bit_num_i > 4'(DATA_MAX) ? 4'(DATA_MAX) : data_bit_num_i;
        div_c = divisor_i < DIV_W'(2) ? DIV_W'(2) : divisor_i;
        div_m1 = {1'b0, div_q} - 1'b1;
        // one-and-half stop uses floor(DIV/2); two-stop encodings 10 and 11 share 2*DIV
        stop_len = sb_q == STOP_NUM_1  ? {1'b0, div_q} :
                   sb_q == STOP_NUM_15 ? {1'b0, div_q} + CW'(div_q >> 1) : {div_q, 1'b0};
        par_en = pt_q == PARITY_EVEN || pt_q == PARITY_ODD;
        state_d = state_q;
        shift_d = shift_q;
        par_d = par_q;
        bit_d = bit_q;
        dn_d = dn_q;
        pt_d = pt_q;
        sb_d = sb_q;
        div_d = div_q;
        load = 1'b0;
        load_val = div_m1;
        case (state_q)
            ST_IDLE: if (shoot_i) begin
                state_d = ST_START;
                shift_d = datatx_i;
                par_d = 1'b0;
                bit_d = '0;
                dn_d = dn_c;
                pt_d = parity_type_i;
                sb_d = stop_bit_num_i;
                div_d = div_c;
                load = 1'b1;
                load_val = {1'b0, div_c} - 1'b1;
            end
            ST_START: if (tick) begin
                state_d = ST_DATA;
                load = 1'b1;
            end
            ST_DATA: if (tick) begin
                par_d = par_q ^ shift_q[0];
                shift_d = shift_q >> 1;
                bit_d = bit_q + 3'd1;
                load = 1'b1;
                if ({1'b0, bit_q} == dn_q - 4'd1) begin
                    state_d = par_en ? ST_PARITY : ST_STOP;
                    load_val = par_en ? div_m1 : stop_len - 1'b1;
                end
            end
            ST_PARITY: if (tick) begin
                state_d = ST_STOP;
                load = 1'b1;
                load_val = stop_len - 1'b1;
            end
            ST_STOP: if (tick) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // outputs are registered from the next state so they line up with it
        tx_d = state_d == ST_START ? 1'b0 :
               state_d == ST_DATA ? shift_d[0] :
               state_d == ST_PARITY ? par_d ^ (pt_q == PARITY_ODD) : 1'b1;
        busy_d = state_d != ST_IDLE;
        // stop field is at least 2 cycles, so count 1 always precedes the final cycle
        done_d = state_q == ST_STOP && cnt == CW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            par_q <= 1'b0;
            bit_q <= '0;
            dn_q <= '0;
            pt_q <= '0;
            sb_q <= '0;
            div_q <= '0;
            tx_q <= 1'b1;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            par_q <= par_d;
            bit_q <= bit_d;
            dn_q <= dn_d;
            pt_q <= pt_d;
            sb_q <= sb_d;
            div_q <= div_d;
            tx_q <= tx_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign tx_o = tx_q;
    assign busy_o = busy_q;
    assign done_o = done_q;
endmodule

// File: tb/tb_myuart_tx.sv
// tb_myuart_tx: directed self-checking bench for myuart_tx
module tb_myuart_tx;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        shoot_i = 1'b0;
    logic [7:0]  datatx_i = 8'h00;
    logic [3:0]  data_bit_num_i = 4'd8;
    logic [1:0]  parity_type_i = 2'b00;
    logic [1:0]  stop_bit_num_i = 2'b00;
    logic [15:0] divisor_i = 16'd4;
    logic        tx_o, busy_o, done_o;
    int tests = 0;
    int fails = 0;
    logic cap_tx [300];
    logic cap_done [300];
    int n = 0;
    bit disturb = 1'b0;

    always #5 clk_i = ~clk_i;

    myuart_tx dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .shoot_i        (shoot_i),
        .datatx_i       (datatx_i),
        .data_bit_num_i (data_bit_num_i),
        .parity_type_i  (parity_type_i),
        .stop_bit_num_i (stop_bit_num_i),
        .divisor_i      (divisor_i),
        .tx_o           (tx_o),
        .busy_o         (busy_o),
        .done_o         (done_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cfg(input logic [7:0] d, input logic [3:0] nb, input logic [1:0] par,
                       input logic [1:0] stp, input logic [15:0] div);
        datatx_i = d;
        data_bit_num_i = nb;
        parity_type_i = par;
        stop_bit_num_i = stp;
        divisor_i = div;
    endtask

    task automatic shoot();
        shoot_i = 1'b1;
        tick();
        shoot_i = 1'b0;
    endtask

    task automatic capture();
        n = 0;
        while (busy_o && n < 300) begin
            cap_tx[n] = tx_o;
            cap_done[n] = done_o;
            if (disturb && n == 6) begin
                shoot_i = 1'b1;
                cfg(8'h00, 4'd5, 2'b10, 2'b10, 16'd9);
            end
            if (disturb && n == 7) shoot_i = 1'b0;
            n++;
            tick();
        end
    endtask

    // bits_v holds the hand-derived bits following the start bit, first-sent in bit 0
    task automatic check_frame(input string tag, input logic [15:0] bits_v, input int nb,
                               input int div, input int exp_len);
        int mism = 0;
        int dones = 0;
        logic e;
        for (int c = 0; c < n; c++) begin
            e = (c / div == 0) ? 1'b0 : (c / div <= nb) ? bits_v[c / div - 1] : 1'b1;
            if (cap_tx[c] !== e) mism++;
            if (cap_done[c] === 1'b1) dones++;
        end
        check({tag, " busy_len"}, n, exp_len);
        check({tag, " wave_mismatches"}, mism, 0);
        check({tag, " done_count"}, dones, 1);
        check({tag, " done_last"}, (n > 0) ? cap_done[n-1] : 1'b0, 1'b1);
        check({tag, " idle_tx"}, tx_o, 1'b1);
        check({tag, " idle_done"}, done_o, 1'b0);
    endtask

    initial begin
        int d_cnt;
        tick();
        tick();
        check("reset tx", tx_o, 1'b1);
        check("reset busy", busy_o, 1'b0);
        check("reset done", done_o, 1'b0);
        rst_i = 1'b0;
        tick();

        cfg(8'h55, 4'd8, 2'b00, 2'b00, 16'd4);
        shoot();
        check("8N1 first busy", busy_o, 1'b1);
        check("8N1 first tx", tx_o, 1'b0);
        capture();
        check_frame("8N1", 16'h0055, 8, 4, 40);

        cfg(8'h55, 4'd8, 2'b00, 2'b00, 16'd4);
        shoot();
        disturb = 1'b1;
        capture();
        disturb = 1'b0;
        check_frame("8N1 disturbed", 16'h0055, 8, 4, 40);

        cfg(8'hC3, 4'd7, 2'b01, 2'b10, 16'd10);
        shoot();
        capture();
        check_frame("7E2", 16'h00C3, 8, 10, 110);

        cfg(8'hFF, 4'd2, 2'b10, 2'b01, 16'd5);
        shoot();
        capture();
        check_frame("5O1.5", 16'h001F, 6, 5, 42);

        // shoot in the first cycle with busy_o low; clamps: 12->8 bits, div 0->2, parity 11, stop 11
        cfg(8'h2D, 4'd12, 2'b11, 2'b11, 16'd0);
        shoot();
        check("b2b start tx", tx_o, 1'b0);
        capture();
        check_frame("b2b clamp", 16'h002D, 8, 2, 22);

        cfg(8'h55, 4'd8, 2'b00, 2'b00, 16'd4);
        shoot();
        repeat (10) tick();
        check("mid data busy", busy_o, 1'b1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("abort tx", tx_o, 1'b1);
        check("abort busy", busy_o, 1'b0);
        check("abort done", done_o, 1'b0);
        d_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            if (done_o !== 1'b0 || busy_o !== 1'b0 || tx_o !== 1'b1) d_cnt++;
            tick();
        end
        check("abort quiet", d_cnt, 0);

        cfg(8'hA5, 4'd8, 2'b00, 2'b00, 16'd3);
        shoot();
        capture();
        check_frame("after abort", 16'h00A5, 8, 3, 30);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
